branch_ctrl: RTL and testbench

//  Control-flow source for the program counter: drives branch_en, reljump_en, absjump_en and target.

---
 rtl/branch_pkg.sv | 26 ++
 rtl/branch_ctrl_if.sv | 36 +++
 rtl/ret_stack.sv | 40 ++++
 rtl/branch_ctrl.sv | 139 +++++++++++++
 tb/tb_branch_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types and default sizes for the branch controller slice.
package branch_pkg;

    localparam int unsigned D_DEF      = 12;
    localparam int unsigned LUTW_DEF   = 4;
    localparam int unsigned SDEPTH_DEF = 4;

    // Decoded control-flow operation; codes 3'd7 and above are reserved.
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_JMP  = 3'd1,
        BR_REL  = 3'd2,
        BR_BZ   = 3'd3,
        BR_BN   = 3'd4,
        BR_CALL = 3'd5,
        BR_RET  = 3'd6
    } br_op_t;

    // Enable triple presented to the PC.
    typedef struct packed {
        logic branch_en;
        logic reljump_en;
        logic absjump_en;
    } br_en_t;

endpackage

// File: rtl/branch_ctrl_if.sv
// Decoder/ALU/PC-facing bus of the branch controller.
interface branch_ctrl_if
    import branch_pkg::*;
#(
    parameter int unsigned D    = D_DEF,
    parameter int unsigned LUTW = LUTW_DEF
);
    br_op_t          br_op;
    logic [LUTW-1:0] lut_idx;
    logic [D-1:0]    prog_ctr;
    logic            flag_we;
    logic            alu_zero;
    logic            alu_neg;
    logic            lut_we;
    logic [LUTW-1:0] lut_waddr;
    logic [D-1:0]    lut_wdata;
    logic            branch_en;
    logic            reljump_en;
    logic            absjump_en;
    logic [D-1:0]    target;
    logic            stk_err;

    // Decoder / ALU / program-load side.
    modport master (
        output br_op, lut_idx, prog_ctr, flag_we, alu_zero, alu_neg,
               lut_we, lut_waddr, lut_wdata,
        input  branch_en, reljump_en, absjump_en, target, stk_err
    );

    // Branch controller side.
    modport slave (
        input  br_op, lut_idx, prog_ctr, flag_we, alu_zero, alu_neg,
               lut_we, lut_waddr, lut_wdata,
        output branch_en, reljump_en, absjump_en, target, stk_err
    );
endinterface

// File: rtl/ret_stack.sv
// Call/return address stack; top of stack is readable combinationally.
module ret_stack #(
    parameter int unsigned D      = 12,
    parameter int unsigned SDEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] din,
    output logic [D-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int unsigned PW = $clog2(SDEPTH + 1);
    localparam int unsigned AW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

    logic [PW-1:0] sp;
    logic [D-1:0]  mem [SDEPTH];

    assign full  = (sp == PW'(SDEPTH));
    assign empty = (sp == '0);
    assign dout  = empty ? '0 : mem[AW'(sp - PW'(1))];

    // Push has priority in the encoding, but the caller never asserts both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
            for (int i = 0; i < int'(SDEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[AW'(sp)] <= din;
            sp           <= sp + PW'(1);
        end else if (pop && !empty) begin
            sp <= sp - PW'(1);
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: flag register, jump-target LUT and return stack feeding the PC.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned D      = D_DEF,
    parameter int unsigned LUTW   = LUTW_DEF,
    parameter int unsigned SDEPTH = SDEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    branch_ctrl_if.slave  bus
);
    localparam int unsigned LUT_N = 2 ** LUTW;

    logic         flag_z;
    logic         flag_n;
    logic [D-1:0] lut [LUT_N];
    logic [D-1:0] lut_rd;
    logic [D-1:0] stk_top;
    logic         stk_full;
    logic         stk_empty;
    logic         push_c;
    logic         pop_c;
    logic         err_set_c;
    logic         stk_err;
    br_en_t       en_c;
    logic [D-1:0] target_c;

    // Latch ALU condition flags for later branch decisions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (bus.flag_we) begin
            flag_z <= bus.alu_zero;
            flag_n <= bus.alu_neg;
        end
    end

    // Jump-target LUT: written at program load, read-before-write on collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(LUT_N); i++) begin
                lut[i] <= '0;
            end
        end else if (bus.lut_we) begin
            lut[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

    assign lut_rd = lut[bus.lut_idx];

    ret_stack #(
        .D      (D),
        .SDEPTH (SDEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .pop   (pop_c),
        .din   (D'(bus.prog_ctr + D'(1))),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Decode the branch op into PC enables, target and stack actions.
    always_comb begin
        en_c      = '0;
        target_c  = '0;
        push_c    = 1'b0;
        pop_c     = 1'b0;
        err_set_c = 1'b0;
        unique case (bus.br_op)
            BR_JMP: begin
                en_c     = '{branch_en: 1'b1, reljump_en: 1'b0, absjump_en: 1'b1};
                target_c = lut_rd;
            end
            BR_REL: begin
                en_c     = '{branch_en: 1'b1, reljump_en: 1'b1, absjump_en: 1'b0};
                target_c = lut_rd;
            end
            BR_BZ: begin
                if (flag_z) begin
                    en_c     = '{branch_en: 1'b1, reljump_en: 1'b1, absjump_en: 1'b0};
                    target_c = lut_rd;
                end
            end
            BR_BN: begin
                if (flag_n) begin
                    en_c     = '{branch_en: 1'b1, reljump_en: 1'b1, absjump_en: 1'b0};
                    target_c = lut_rd;
                end
            end
            BR_CALL: begin
                if (stk_full) begin
                    err_set_c = 1'b1;
                end else begin
                    en_c     = '{branch_en: 1'b1, reljump_en: 1'b0, absjump_en: 1'b1};
                    target_c = lut_rd;
                    push_c   = 1'b1;
                end
            end
            BR_RET: begin
                if (stk_empty) begin
                    err_set_c = 1'b1;
                end else begin
                    en_c     = '{branch_en: 1'b1, reljump_en: 1'b0, absjump_en: 1'b1};
                    target_c = stk_top;
                    pop_c    = 1'b1;
                end
            end
            default: begin
                en_c     = '0;
                target_c = '0;
            end
        endcase
        if (reset) begin
            en_c     = '0;
            target_c = '0;
        end
    end

    // Sticky stack error, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stk_err <= 1'b0;
        end else if (err_set_c) begin
            stk_err <= 1'b1;
        end
    end

    assign bus.branch_en  = en_c.branch_en;
    assign bus.reljump_en = en_c.reljump_en;
    assign bus.absjump_en = en_c.absjump_en;
    assign bus.target     = target_c;
    assign bus.stk_err    = stk_err;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus random traffic vs a behavioural model.
module tb_branch_ctrl;
    import branch_pkg::*;

    localparam int unsigned D      = 12;
    localparam int unsigned LUTW   = 4;
    localparam int unsigned SDEPTH = 4;

    logic clk;
    logic reset;

    branch_ctrl_if #(.D(D), .LUTW(LUTW)) bus ();

    branch_ctrl #(.D(D), .LUTW(LUTW), .SDEPTH(SDEPTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    bit       m_z;
    bit       m_n;
    bit       m_err;
    int       m_lut [16];
    int       m_stk [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_z   = 0;
        m_n   = 0;
        m_err = 0;
        m_stk.delete();
        foreach (m_lut[i]) m_lut[i] = 0;
    endtask

    // Compare all outputs against the model for the currently driven inputs.
    task automatic compare();
        int op;
        int br, rel, ab, tgt;
        op = int'(bus.br_op);
        br = 0; rel = 0; ab = 0; tgt = 0;
        if (!reset) begin
            if (op == 1 || (op == 5 && m_stk.size() < int'(SDEPTH))) begin
                br = 1; ab = 1; tgt = m_lut[bus.lut_idx];
            end else if (op == 2 || (op == 3 && m_z) || (op == 4 && m_n)) begin
                br = 1; rel = 1; tgt = m_lut[bus.lut_idx];
            end else if (op == 6 && m_stk.size() > 0) begin
                br = 1; ab = 1; tgt = m_stk[$];
            end
        end
        check("branch_en",  32'(bus.branch_en),  32'(br));
        check("reljump_en", 32'(bus.reljump_en), 32'(rel));
        check("absjump_en", 32'(bus.absjump_en), 32'(ab));
        check("target",     32'(bus.target),     32'(tgt));
        check("stk_err",    32'(bus.stk_err),    32'(m_err));
        check("invariant",
              32'((bus.reljump_en && bus.absjump_en) ||
                  (bus.branch_en && !(bus.reljump_en ^ bus.absjump_en))), 32'd0);
    endtask

    task automatic apply(input int op, input int idx, input int pc,
                         input bit fwe, input bit az, input bit an,
                         input bit lwe, input int lwa, input int lwd);
        bus.br_op     = br_op_t'(3'(op));
        bus.lut_idx   = 4'(idx);
        bus.prog_ctr  = 12'(pc);
        bus.flag_we   = fwe;
        bus.alu_zero  = az;
        bus.alu_neg   = an;
        bus.lut_we    = lwe;
        bus.lut_waddr = 4'(lwa);
        bus.lut_wdata = 12'(lwd);
        #1;
        compare();
    endtask

    // Advance one clock and apply the cycle's effects to the model.
    task automatic tick();
        int op;
        @(posedge clk);
        op = int'(bus.br_op);
        if (!reset) begin
            if (op == 5) begin
                if (m_stk.size() < int'(SDEPTH)) m_stk.push_back((int'(bus.prog_ctr) + 1) % 4096);
                else m_err = 1;
            end else if (op == 6) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_err = 1;
            end
            if (bus.flag_we) begin
                m_z = bus.alu_zero;
                m_n = bus.alu_neg;
            end
            if (bus.lut_we) m_lut[bus.lut_waddr] = int'(bus.lut_wdata);
        end
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        compare();
        check("rst_stk_err", 32'(bus.stk_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;

        // 1: reset state.
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t1_br", 32'(bus.branch_en), 32'd0);
        check("t1_err", 32'(bus.stk_err), 32'd0);
        tick();

        // 2: absolute jump through the LUT; same-cycle write reads old value.
        apply(1, 3, 0, 0, 0, 0, 1, 3, 12'h040);
        check("t2_old", 32'(bus.target), 32'd0);
        tick();
        apply(1, 3, 0, 0, 0, 0, 0, 0, 0);
        check("t2_abs", 32'(bus.absjump_en), 32'd1);
        check("t2_tgt", 32'(bus.target), 32'h040);
        tick();

        // 3: branch on registered Z.
        apply(0, 0, 0, 1, 1, 0, 1, 5, 12'hFFE);
        tick();
        apply(3, 5, 0, 1, 0, 0, 0, 0, 0);
        check("t3_rel", 32'(bus.reljump_en), 32'd1);
        check("t3_tgt", 32'(bus.target), 32'hFFE);
        tick();
        apply(3, 5, 0, 0, 0, 0, 0, 0, 0);
        check("t3_nz", 32'(bus.branch_en), 32'd0);
        tick();

        // 4: call and return.
        apply(5, 3, 12'h010, 0, 0, 0, 0, 0, 0);
        check("t4_call", 32'(bus.target), 32'h040);
        tick();
        apply(6, 0, 12'h040, 0, 0, 0, 0, 0, 0);
        check("t4_ret_abs", 32'(bus.absjump_en), 32'd1);
        check("t4_ret_tgt", 32'(bus.target), 32'h011);
        tick();

        // 5: overflow on the fifth call, then LIFO returns.
        for (int i = 0; i < 4; i++) begin
            apply(5, 3, 12'h100 + i, 0, 0, 0, 0, 0, 0);
            tick();
        end
        apply(5, 3, 12'h200, 0, 0, 0, 0, 0, 0);
        check("t5_full_br", 32'(bus.branch_en), 32'd0);
        tick();
        check("t5_err", 32'(bus.stk_err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            apply(6, 0, 0, 0, 0, 0, 0, 0, 0);
            check("t5_lifo", 32'(bus.target), 32'(12'h104 - i));
            tick();
        end

        // 6: underflow, then reset mid-call sequence.
        pulse_reset();
        apply(6, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t6_empty_br", 32'(bus.branch_en), 32'd0);
        tick();
        check("t6_err", 32'(bus.stk_err), 32'd1);
        apply(5, 3, 12'h300, 0, 0, 0, 0, 0, 0);
        tick();
        apply(5, 3, 12'h301, 0, 0, 0, 0, 0, 0);
        pulse_reset();
        apply(6, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t6_rst_empty", 32'(bus.branch_en), 32'd0);
        tick();

        // Random traffic, biased toward CALL/RET to reach full and empty.
        for (int c = 0; c < 3000; c++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op > 7) op = (op == 8) ? 5 : 6;
            apply(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)));
            if ($urandom_range(0, 299) == 0) pulse_reset();
            else tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
